// File: rtl/div_unit_if.sv
// Divider request/response bundle between the EX stage and div_unit.
//
// Handshake: the master raises start together with signed_div/opdata1/
// opdata2 and keeps start high until it observes ready=1. Operands only
// need to be valid on the edge that accepts start. result is valid only
// while ready=1 and reads 0 otherwise. The master drops start to release
// the result. annul aborts a division in flight.
//
// Signals:
//   signed_div  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1     dividend
//   opdata2     divisor
//   start       request, held until ready is seen
//   annul       pipeline flush, aborts an in-flight division
//   result      {remainder, quotient}
//   ready       result valid
interface div_unit_if;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU. One quotient bit is
// produced per cycle, MSB first, on operand magnitudes. A final fix-up
// cycle applies the signs. A zero divisor short-circuits to result 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        div_unit_if.slave (operands, start/annul, result/ready)
//   fsm_state  current FSM state (FREE=0, BYZERO=1, ON=2, END=3)
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    // [64:33] partial remainder, [32:1] dividend bits still to consume,
    // quotient bits shift in at [0]. After 32 steps the quotient is in
    // [31:0] and the remainder is in [64:33].
    logic [64:0] work, work_n;
    logic [31:0] divisor, divisor_n;
    logic        sdiv, sdiv_n;
    logic        sign1, sign1_n;
    logic        sign2, sign2_n;
    logic [63:0] result_q, result_n;
    logic        ready_q, ready_n;

    logic [31:0] mag1, mag2;
    logic [32:0] trial;
    logic [31:0] quot_fix, rem_fix;

    // Magnitudes are only taken in signed mode. Unsigned operands pass through.
    assign mag1 = (bus.signed_div && bus.opdata1[31]) ? (~bus.opdata1 + 32'd1) : bus.opdata1;
    assign mag2 = (bus.signed_div && bus.opdata2[31]) ? (~bus.opdata2 + 32'd1) : bus.opdata2;

    // Bit 32 of trial set means the subtraction went negative.
    assign trial = {1'b0, work[63:32]} - {1'b0, divisor};

    // The quotient is negative when the signs differ. The remainder takes
    // the sign of the dividend.
    assign quot_fix = (sdiv && (sign1 ^ sign2)) ? (~work[31:0] + 32'd1) : work[31:0];
    assign rem_fix  = (sdiv && sign1) ? (~work[64:33] + 32'd1) : work[64:33];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        sdiv_n    = sdiv;
        sign1_n   = sign1;
        sign2_n   = sign2;
        result_n  = result_q;
        ready_n   = ready_q;

        case (state)
            FREE: begin
                if (bus.start && !bus.annul) begin
                    if (bus.opdata2 == 32'd0) begin
                        state_n = BYZERO;
                    end else begin
                        state_n   = ON;
                        sdiv_n    = bus.signed_div;
                        sign1_n   = bus.opdata1[31];
                        sign2_n   = bus.opdata2[31];
                        work_n    = {32'd0, mag1, 1'b0};
                        divisor_n = mag2;
                        cnt_n     = 6'd0;
                    end
                end
            end
            BYZERO: begin
                if (bus.annul) begin
                    state_n = FREE;
                end else begin
                    state_n  = END;
                    result_n = 64'd0;
                    ready_n  = 1'b1;
                end
            end
            ON: begin
                if (bus.annul) begin
                    state_n = FREE;
                end else if (cnt == 6'd32) begin
                    state_n  = END;
                    result_n = {rem_fix, quot_fix};
                    ready_n  = 1'b1;
                end else begin
                    if (trial[32]) begin
                        work_n = {work[63:0], 1'b0};
                    end else begin
                        work_n = {trial[31:0], work[31:0], 1'b1};
                    end
                    cnt_n = cnt + 6'd1;
                end
            end
            END: begin
                // annul is ignored here; only dropping start releases the result.
                if (!bus.start) begin
                    state_n  = FREE;
                    result_n = 64'd0;
                    ready_n  = 1'b0;
                end
            end
            default: state_n = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            work     <= 65'd0;
            divisor  <= 32'd0;
            sdiv     <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            work     <= work_n;
            divisor  <= divisor_n;
            sdiv     <= sdiv_n;
            sign1    <= sign1_n;
            sign2    <= sign2_n;
            result_q <= result_n;
            ready_q  <= ready_n;
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of hand-computed division
// vectors plus directed sequences for annul, reset-in-flight and
// divide-by-zero corner cases.
module tb_div_unit;

    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;

    div_unit_if bus_if ();

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .fsm_state (fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          hold;
        bit          scramble;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          total;
    int          passed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus_if.signed_div = 1'b0;
        bus_if.opdata1    = 32'd0;
        bus_if.opdata2    = 32'd0;
        bus_if.start      = 1'b0;
        bus_if.annul      = 1'b0;
    endtask

    // Driver: one full division, checks latency, result, zero-before-ready,
    // stability while start is held, and release on start drop.
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input int hold, input bit scramble,
                           input string tag);
        logic [63:0] exp_r;
        logic [63:0] held;
        int          lat;
        bit          early;
        exp_r = exp_q.pop_front();
        @(negedge clk);
        bus_if.signed_div = sd;
        bus_if.opdata1    = a;
        bus_if.opdata2    = b;
        bus_if.start      = 1'b1;
        bus_if.annul      = 1'b0;
        @(posedge clk);  // E0
        lat   = 0;
        early = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_if.ready) break;
            if (bus_if.result != 64'd0) early = 1'b1;
            if (scramble) begin
                bus_if.opdata1    = $urandom;
                bus_if.opdata2    = $urandom;
                bus_if.signed_div = 1'($urandom_range(0, 1));
            end
        end
        check({tag, " ready"}, 64'(bus_if.ready), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, bus_if.result, exp_r);
        check({tag, " zero_before_ready"}, 64'(early), 64'd0);
        held = bus_if.result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold_result"}, bus_if.result, held);
            check({tag, " hold_ready"}, 64'(bus_if.ready), 64'd1);
        end
        @(negedge clk);
        bus_if.start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " release_ready"}, 64'(bus_if.ready), 64'd0);
        check({tag, " release_result"}, bus_if.result, 64'd0);
        check({tag, " release_state"}, 64'(fsm_state), 64'd0);
    endtask

    // Start a division and hit rst after cnt reaches 20.
    task automatic reset_mid(input bit with_annul, input string tag);
        @(negedge clk);
        bus_if.signed_div = 1'b0;
        bus_if.opdata1    = 32'hCAFEF00D;
        bus_if.opdata2    = 32'h00000013;
        bus_if.start      = 1'b1;
        @(posedge clk);  // E0
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        bus_if.annul = with_annul;
        @(posedge clk);
        #1;
        check({tag, " ready"}, 64'(bus_if.ready), 64'd0);
        check({tag, " result"}, bus_if.result, 64'd0);
        check({tag, " state"}, 64'(fsm_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        check({tag, " still_free"}, 64'(fsm_state), 64'd0);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(bus_if.ready), 64'd0);
        check("reset result", bus_if.result, 64'd0);
        check("reset state", 64'(fsm_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        //        sd    a             b             expected {rem, quo}     lat hold scr
        vecs.push_back('{1'b0, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 33, 0, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b0});
        vecs.push_back('{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0, 1'b0});
        vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 2, 1'b1});
        vecs.push_back('{1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33, 0, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 0, 1'b1});
        vecs.push_back('{1'b0, 32'h12345678, 32'h12345678, 64'h00000000_00000001, 33, 0, 1'b0});
        vecs.push_back('{1'b0, 32'h00000005, 32'h00000009, 64'h00000005_00000000, 33, 0, 1'b0});
        vecs.push_back('{1'b0, 32'h80000000, 32'h00000003, 64'h00000002_2AAAAAAA, 33, 0, 1'b0});
        vecs.push_back('{1'b0, 32'h12345678, 32'h00000000, 64'h00000000_00000000,  1, 5, 1'b0});
        vecs.push_back('{1'b1, 32'h12345678, 32'h00000000, 64'h00000000_00000000,  1, 5, 1'b0});

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp);
            run_div(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold,
                    vecs[i].scramble, $sformatf("vec%0d", i));
        end

        // Annul with cnt=10, then an unsigned all-ones division.
        begin
            bit saw_ready;
            saw_ready = 1'b0;
            @(negedge clk);
            bus_if.signed_div = 1'b0;
            bus_if.opdata1    = 32'hDEADBEEF;
            bus_if.opdata2    = 32'h00000003;
            bus_if.start      = 1'b1;
            @(posedge clk);  // E0
            repeat (10) begin
                @(posedge clk);
                #1;
                if (bus_if.ready) saw_ready = 1'b1;
            end
            @(negedge clk);
            bus_if.annul = 1'b1;
            @(posedge clk);
            #1;
            check("annul state", 64'(fsm_state), 64'd0);
            check("annul ready", 64'(bus_if.ready), 64'd0);
            @(negedge clk);
            idle_inputs();
            repeat (5) begin
                @(posedge clk);
                #1;
                if (bus_if.ready) saw_ready = 1'b1;
            end
            check("annul never_ready", 64'(saw_ready), 64'd0);
            exp_q.push_back(64'h00000000_FFFFFFFF);
            run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 33, 0, 1'b0, "after_annul");
        end

        // Annul during BYZERO.
        @(negedge clk);
        bus_if.opdata1 = 32'h12345678;
        bus_if.opdata2 = 32'd0;
        bus_if.start   = 1'b1;
        @(posedge clk);  // E0 -> BYZERO
        @(negedge clk);
        bus_if.annul = 1'b1;
        @(posedge clk);
        #1;
        check("byzero_annul state", 64'(fsm_state), 64'd0);
        check("byzero_annul ready", 64'(bus_if.ready), 64'd0);
        @(negedge clk);
        idle_inputs();

        // Reset in flight, with and without annul, each followed by a fresh division.
        reset_mid(1'b0, "rst_mid");
        exp_q.push_back(64'h00000002_0000000E);
        run_div(1'b0, 32'h00000064, 32'h00000007, 33, 0, 1'b0, "after_rst");
        reset_mid(1'b1, "rst_mid_annul");
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 33, 0, 1'b0, "after_rst_annul");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
